fma_dot_sequencer: RTL and testbench
====================================

Name: fma_dot_sequencer

Overview:
- Upstream controller for the Q1.15 `fma` unit; computes a saturating dot product by issuing one MAC per element.
- Accepts a command (vector length, initial accumulator), then pulls activation/weight pairs over a valid/ready stream.
- For each pair it drives the fma's REQUEST → EXECUTE×2 sequence and captures `fma_out` as the next running accumulator.
- Presents the final Q1.15 sum on a valid/ready result port; standalone datapath users and the bench instantiate it next to one `fma`.

Parameters:
- DATA_BITS, 16, Q1.15 operand/result width; must equal the fma's DATA_BITS.
- LEN_BITS, 8, width of the vector-length field; max length 2^LEN_BITS-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  command strobe; sampled only in IDLE
- vec_len  in  LEN_BITS  element count, sampled with start
- acc_init  in  DATA_BITS  initial accumulator (Q1.15), sampled with start
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid && in_ready
- in_act  in  DATA_BITS  activation (Q1.15)
- in_wt  in  DATA_BITS  weight (Q1.15)
- fma_core_state  out  3  drives fma core_state
- fma_decoded_en  out  1  drives fma decoded_fma_enable
- fma_rs / fma_rt / fma_rq  out  DATA_BITS each  drive fma rs/rt/rq
- fma_result  in  DATA_BITS  from fma fma_out
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_result  out  DATA_BITS  final dot product (Q1.15)

Behaviour:
- Reset: asynchronous, active-low. All state is cleared.
  - State goes to IDLE; acc, act/wt and remaining-count registers go to 0.
  - Outputs: busy=0, in_ready=0, out_valid=0, out_result=0, fma_core_state=3'b000, fma_decoded_en=0, fma_rs/rt/rq=0.
- Reset mid-operation: aborts immediately with no partial result. The external fma must share the reset.
- States and encodings driven on fma_core_state:
  - IDLE: 000
  - WAIT_OPND: 000
  - REQUEST: 011
  - EXEC0: 101
  - EXEC1: 101
  - UPDATE: 110
  - DONE: 000
- fma_decoded_en is 1 only in EXEC0 and EXEC1.
- Transitions:
  - IDLE: start && vec_len!=0 → WAIT_OPND; latch acc←acc_init, remaining←vec_len.
  - IDLE: start && vec_len==0 → DONE; acc←acc_init (no MAC issued).
  - WAIT_OPND: in_ready=1; on in_valid, latch act←in_act, wt←in_wt → REQUEST.
  - REQUEST: fma_rs=act, fma_rt=wt, fma_rq=acc; the fma latches them this edge. → EXEC0.
  - EXEC0 → EXEC1: the fma forms the saturated product, then the saturated sum.
  - UPDATE: acc←fma_result, remaining←remaining-1. If remaining==1 → DONE, else WAIT_OPND.
  - DONE: out_valid=1, out_result=acc, held stable until out_ready. On the handshake → IDLE.
- fma_rs/rt/rq are driven from registers in every state; their value outside REQUEST is don't-care to the fma.
- Throughput: 5 cycles per element with in_valid held high. out_valid rises 5·vec_len cycles after the start edge.
- Arithmetic is performed entirely in the fma and must not be duplicated here:
  - product = (a·b)>>>15, saturated to [0x8000, 0x7FFF];
  - sum = saturating add.
- start outside IDLE is ignored, including in DONE. in_act/in_wt are ignored when in_ready=0.
- vec_len = max (all ones) must complete without count wrap.
- in_valid deasserted in WAIT_OPND stalls indefinitely; acc is unchanged.
- out_ready low in DONE stalls indefinitely; out_result stays stable.
- Edge case: out_ready and start both high in DONE → return to IDLE only; that start is not accepted. A new start is taken the next cycle.

Test Plan:
- Basic sum: reset, start vec_len=2, acc_init=0x0000; pairs (0x4000,0x4000)×2 → out_result=0x4000, out_valid 10 cycles after start edge.
- Positive saturation: acc_init=0x7000, pair (0x7FFF,0x7FFF) → product 0x7FFE, sum saturates → out_result=0x7FFF. Pair (0x8000,0x8000) → product saturates to 0x7FFF.
- Negative sum: acc_init=0x0000, pairs (0x8000,0x7FFF),(0x8000,0x7FFF) → products 0x8001 each, sum saturates → out_result=0x8000.
- Zero-length and backpressure: vec_len=0, acc_init=0x1234 → DONE next cycle, out_result=0x1234. With out_ready low 7 cycles, out_valid and result hold and start pulses are ignored; the out_ready handshake returns busy to 0.
- Operand stall: vec_len=3 with in_valid gaps of 0/4/2 cycles → in_ready only in WAIT_OPND, same result as the gap-free run, and fma_core_state never shows 011/101 during stalls.
- Reset mid-op: assert reset low in EXEC1 of element 2 → asynchronously busy=0 and out_valid=0. A fresh command afterwards yields the correct result, unaffected by prior acc.

Source files
------------

// File: rtl/fma_dot_sequencer.sv
// Sequences Q1.15 dot products through an external fma unit, one MAC per operand pair.
// The operand/result streams use valid/ready handshakes; every output is driven from a register.
module fma_dot_sequencer #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned LEN_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_BITS-1:0]  vec_len,
  input  logic [DATA_BITS-1:0] acc_init,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_act,
  input  logic [DATA_BITS-1:0] in_wt,
  output logic [2:0]           fma_core_state,
  output logic                 fma_decoded_en,
  output logic [DATA_BITS-1:0] fma_rs,
  output logic [DATA_BITS-1:0] fma_rt,
  output logic [DATA_BITS-1:0] fma_rq,
  input  logic [DATA_BITS-1:0] fma_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_result
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OPND,
    REQUEST,
    EXEC0,
    EXEC1,
    UPDATE,
    DONE
  } state_t;

  state_t               state, next;
  logic [DATA_BITS-1:0] acc, act, wt;
  logic [LEN_BITS-1:0]  remaining;

  function automatic logic [2:0] core_code(input state_t s);
    case (s)
      REQUEST:      core_code = 3'b011;
      EXEC0, EXEC1: core_code = 3'b101;
      UPDATE:       core_code = 3'b110;
      default:      core_code = 3'b000;
    endcase
  endfunction

  always_comb begin
    next = state;
    case (state)
      IDLE:      if (start) next = (vec_len != '0) ? WAIT_OPND : DONE;
      WAIT_OPND: if (in_valid && in_ready) next = REQUEST;
      REQUEST:   next = EXEC0;
      EXEC0:     next = EXEC1;
      EXEC1:     next = UPDATE;
      UPDATE:    next = (remaining == LEN_BITS'(1)) ? DONE : WAIT_OPND;
      DONE:      if (out_ready) next = IDLE;
      default:   next = IDLE;
    endcase
  end

  // Status and fma-control outputs are registered from the next state so they
  // line up with the state register on every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      acc            <= '0;
      act            <= '0;
      wt             <= '0;
      remaining      <= '0;
      busy           <= 1'b0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      fma_core_state <= 3'b000;
      fma_decoded_en <= 1'b0;
    end else begin
      state          <= next;
      busy           <= (next != IDLE);
      in_ready       <= (next == WAIT_OPND);
      out_valid      <= (next == DONE);
      fma_core_state <= core_code(next);
      fma_decoded_en <= (next == EXEC0) || (next == EXEC1);
      case (state)
        IDLE: if (start) begin
          acc       <= acc_init;
          remaining <= vec_len;
        end
        WAIT_OPND: if (in_valid && in_ready) begin
          act <= in_act;
          wt  <= in_wt;
        end
        UPDATE: begin
          acc       <= fma_result;
          remaining <= remaining - LEN_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  assign fma_rs     = act;
  assign fma_rt     = wt;
  assign fma_rq     = acc;
  assign out_result = acc;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench for fma_dot_sequencer, paired with a behavioural Q1.15 fma model.
module tb_fma_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic [15:0] acc_init;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_act, in_wt;
  logic [2:0]  fma_core_state;
  logic        fma_decoded_en;
  logic [15:0] fma_rs, fma_rt, fma_rq;
  logic [15:0] fma_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] act_v [0:255];
  logic [15:0] wt_v  [0:255];
  int unsigned gap_v [0:255];

  always #5 clk = ~clk;

  fma_dot_sequencer #(.DATA_BITS(16), .LEN_BITS(8)) dut (
    .clk(clk), .reset(rst_n), .start(start), .vec_len(vec_len), .acc_init(acc_init),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wt(in_wt),
    .fma_core_state(fma_core_state), .fma_decoded_en(fma_decoded_en),
    .fma_rs(fma_rs), .fma_rt(fma_rt), .fma_rq(fma_rq), .fma_result(fma_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  // Behavioural fma: latch on REQUEST, product on first EXEC, saturating sum on second.
  logic [15:0] m_a, m_b, m_c, m_prod;
  logic        m_phase;

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767)       sat16 = 16'h7FFF;
    else if (v < -32768) sat16 = 16'h8000;
    else                 sat16 = v[15:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_c <= '0; m_prod <= '0; m_phase <= 1'b0; fma_result <= '0;
    end else if (fma_core_state == 3'b011) begin
      m_a <= fma_rs; m_b <= fma_rt; m_c <= fma_rq; m_phase <= 1'b0;
    end else if (fma_core_state == 3'b101 && fma_decoded_en) begin
      if (!m_phase) begin
        m_prod  <= sat16((int'($signed(m_a)) * int'($signed(m_b))) >>> 15);
        m_phase <= 1'b1;
      end else begin
        fma_result <= sat16(int'($signed(m_c)) + int'($signed(m_prod)));
      end
    end
  end

  task automatic run_vec(input int unsigned len, input logic [15:0] init,
                         output logic [15:0] res, output int unsigned cyc);
    int unsigned t;
    cyc = 0;
    res = '0;
    start = 1'b1; vec_len = len[7:0]; acc_init = init;
    @(posedge clk); #1;
    start = 1'b0;
    for (int unsigned e = 0; e < len; e++) begin
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; cyc++; t++; end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_timeout element %0d: in_ready=%b required 1", e, in_ready);
        return;
      end
      for (int unsigned g = 0; g < gap_v[e]; g++) begin
        checks++;
        if (fma_core_state !== 3'b000 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stall_state element %0d: core_state=%b in_ready=%b required 000/1",
                   e, fma_core_state, in_ready);
        end
        @(posedge clk); #1; cyc++;
      end
      in_valid = 1'b1; in_act = act_v[e]; in_wt = wt_v[e];
      @(posedge clk); #1; cyc++;
      in_valid = 1'b0; in_act = 16'h7FFF; in_wt = 16'h7FFF;
    end
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; cyc++; t++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
    end
    res = out_result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume: busy=%b out_valid=%b required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; vec_len = '0; acc_init = '0;
    in_valid = 1'b0; in_act = '0; in_wt = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, out_valid, fma_decoded_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/in_ready/out_valid/en=%b required 0000",
               {busy, in_ready, out_valid, fma_decoded_en});
    end
    checks++;
    if (fma_core_state !== 3'b000 || out_result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: core_state=%b out_result=%h required 000/0000",
               fma_core_state, out_result);
    end
    checks++;
    if (fma_rs !== 16'h0 || fma_rt !== 16'h0 || fma_rq !== 16'h0) begin
      errors++;
      $display("FAIL reset_operands: rs=%h rt=%h rq=%h required 0", fma_rs, fma_rt, fma_rq);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sum();
    logic [15:0] r; int unsigned c;
    for (int i = 0; i < 2; i++) begin act_v[i] = 16'h4000; wt_v[i] = 16'h4000; gap_v[i] = 0; end
    run_vec(2, 16'h0000, r, c);
    checks++;
    if (r !== 16'h4000) begin errors++; $display("FAIL basic_sum: got %h required 4000", r); end
    checks++;
    if (c !== 10) begin errors++; $display("FAIL basic_latency: got %0d cycles required 10", c); end
    consume();
  endtask

  task automatic test_pos_saturation();
    logic [15:0] r; int unsigned c;
    act_v[0] = 16'h7FFF; wt_v[0] = 16'h7FFF; gap_v[0] = 0;
    run_vec(1, 16'h7000, r, c);
    checks++;
    if (r !== 16'h7FFF) begin errors++; $display("FAIL pos_sat_sum: got %h required 7FFF", r); end
    checks++;
    if (c !== 5) begin errors++; $display("FAIL pos_sat_latency: got %0d required 5", c); end
    consume();
    act_v[0] = 16'h8000; wt_v[0] = 16'h8000;
    run_vec(1, 16'h0000, r, c);
    checks++;
    if (r !== 16'h7FFF) begin errors++; $display("FAIL pos_sat_product: got %h required 7FFF", r); end
    consume();
  endtask

  task automatic test_neg_sum();
    logic [15:0] r; int unsigned c;
    for (int i = 0; i < 2; i++) begin act_v[i] = 16'h8000; wt_v[i] = 16'h7FFF; gap_v[i] = 0; end
    run_vec(2, 16'h0000, r, c);
    checks++;
    if (r !== 16'h8000) begin errors++; $display("FAIL neg_sum: got %h required 8000", r); end
    consume();
  endtask

  task automatic test_zero_len_backpressure();
    start = 1'b1; vec_len = 8'd0; acc_init = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h1234) begin
      errors++;
      $display("FAIL zero_len_done: out_valid=%b result=%h required 1/1234", out_valid, out_result);
    end
    for (int i = 0; i < 7; i++) begin
      start = i[0]; vec_len = 8'd2; acc_init = 16'h5555;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'h1234 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b result=%h busy=%b required 1/1234/1",
                 i, out_valid, out_result, busy);
      end
    end
    // Handshake with start high: only the return to IDLE happens this edge.
    start = 1'b1; vec_len = 8'd0; acc_init = 16'h0042; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ignored: busy=%b out_valid=%b required 0/0", busy, out_valid);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h0042) begin
      errors++;
      $display("FAIL start_after_done: valid=%b result=%h required 1/0042", out_valid, out_result);
    end
    consume();
  endtask

  task automatic test_operand_stall();
    logic [15:0] r; int unsigned c;
    act_v[0] = 16'h2000; wt_v[0] = 16'h4000; gap_v[0] = 0;
    act_v[1] = 16'h4000; wt_v[1] = 16'h2000; gap_v[1] = 4;
    act_v[2] = 16'hE000; wt_v[2] = 16'h4000; gap_v[2] = 2;
    run_vec(3, 16'h0100, r, c);
    checks++;
    if (r !== 16'h1100) begin errors++; $display("FAIL stall_result: got %h required 1100", r); end
    checks++;
    if (c !== 21) begin errors++; $display("FAIL stall_latency: got %0d required 21", c); end
    consume();
  endtask

  task automatic test_reset_midop();
    logic [15:0] r; int unsigned c;
    int unsigned t;
    start = 1'b1; vec_len = 8'd3; acc_init = 16'h3000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e < 2; e++) begin
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
      in_valid = 1'b1; in_act = 16'h4000; in_wt = 16'h4000;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fma_core_state !== 3'b101 || fma_decoded_en !== 1'b1) begin
      errors++;
      $display("FAIL exec1_reached: core_state=%b en=%b required 101/1", fma_core_state, fma_decoded_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || fma_core_state !== 3'b000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b core_state=%b in_ready=%b required 0/0/000/0",
               busy, out_valid, fma_core_state, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    act_v[0] = 16'h4000; wt_v[0] = 16'h4000; gap_v[0] = 0;
    run_vec(1, 16'h0000, r, c);
    checks++;
    if (r !== 16'h2000) begin errors++; $display("FAIL after_reset_result: got %h required 2000", r); end
    consume();
  endtask

  task automatic test_max_len();
    logic [15:0] r; int unsigned c;
    for (int i = 0; i < 255; i++) begin act_v[i] = 16'h0080; wt_v[i] = 16'h0100; gap_v[i] = 0; end
    run_vec(255, 16'h0000, r, c);
    checks++;
    if (r !== 16'h00FF) begin errors++; $display("FAIL max_len_result: got %h required 00FF", r); end
    checks++;
    if (c !== 1275) begin errors++; $display("FAIL max_len_latency: got %0d required 1275", c); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_pos_saturation();
    test_neg_sum();
    test_zero_len_backpressure();
    test_operand_stall();
    test_reset_midop();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
